frame_window_stream: RTL and testbench

Parametrised streaming framer and windower for the MFCC front end. It sits between pre-emphasis and the FFT stage. It buffers incoming samples in a circular buffer and cuts them into overlapping frames with a runtime-programmable length and hop. Each frame sample is multiplied by a coefficient from a software-loaded window RAM, so the window shape is not fixed to Hamming. Both the sample input and the frame output use ready/valid handshakes with full backpressure and never drop a sample.

---
 rtl/frame_window_stream_if.sv | 25 ++
 rtl/frame_window_stream.sv | 164 ++++++++++++++++
 tb/tb_frame_window_stream.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_window_stream_if.sv
// Stream bundle for frame_window_stream: sample input and windowed frame output.
interface frame_window_stream_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_first;
  logic                     out_last;

  // environment side: produces samples, consumes frames
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_first, out_last
  );

  // framer side
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_first, out_last
  );
endinterface

// File: rtl/frame_window_stream.sv
// Streaming framer/windower: circular sample buffer cut into overlapping frames
// of programmable length/hop, each sample scaled by a RAM-held window coefficient.
module frame_window_stream #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int MAX_FRAME = 512,
  parameter int LEN_W     = $clog2(MAX_FRAME) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_load,
  input  logic [LEN_W-1:0]         cfg_frame_len,
  input  logic [LEN_W-1:0]         cfg_hop,
  input  logic                     cfg_win_en,
  input  logic                     coef_wr_en,
  input  logic [LEN_W-2:0]         coef_wr_addr,
  input  logic signed [COEF_W-1:0] coef_wr_data,
  frame_window_stream_if.slave     st,
  output logic                     busy
);
  localparam int AW     = LEN_W - 1;
  localparam int PW     = DATA_W + COEF_W;
  localparam int STAGES = 3;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME);
  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;
  localparam logic signed [PW-1:0] RND    = PW'(2 ** (COEF_W - 2));
  localparam logic signed [PW-1:0] SAT_HI = PW'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [PW-1:0] SAT_LO = ~SAT_HI;

  logic [LEN_W-1:0] len, hop, len_c, hop_c, count, cnt_after;
  logic             win_en;
  logic [0:0]       state;
  logic [AW-1:0]    base, k, wr_addr, rd_addr;
  logic             stall, issue, issue_last, wr, in_rdy;

  logic signed [DATA_W-1:0] sbuf [MAX_FRAME];
  logic signed [COEF_W-1:0] cmem [MAX_FRAME];

  logic [STAGES:0]          vld_pipe, fst_pipe, lst_pipe;
  logic signed [DATA_W-1:0] s1_smp, s2_smp, win_res, out_q;
  logic signed [COEF_W-1:0] s1_coef;
  logic signed [PW-1:0]     s2_prod, rnd, shf;

  // clamp incoming config so the datapath never sees len<2 or hop outside 1..len
  always_comb begin
    len_c = cfg_frame_len;
    if (cfg_frame_len < LEN_W'(2))   len_c = LEN_W'(2);
    else if (cfg_frame_len > MAX_LEN) len_c = MAX_LEN;
    hop_c = cfg_hop;
    if (cfg_hop == '0 || cfg_hop > len_c) hop_c = len_c;
  end

  // the write region (base+count..) never overlaps the frame being read,
  // so input acceptance is independent of the emit state
  assign in_rdy      = (count < MAX_LEN) & ~cfg_load;
  assign wr          = st.in_valid & in_rdy;
  assign wr_addr     = base + count[AW-1:0];
  assign rd_addr     = base + k;
  assign stall       = st.out_valid & ~st.out_ready;
  assign issue       = (state == S_EMIT) & ~stall & ~cfg_load;
  assign issue_last  = issue & ({1'b0, k} == len - LEN_W'(1));
  assign cnt_after   = count + LEN_W'(wr) - (issue_last ? hop : '0);

  // config latch, buffer bookkeeping and FILL/EMIT control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len    <= MAX_LEN;
      hop    <= LEN_W'(MAX_FRAME / 2);
      win_en <= 1'b1;
      state  <= S_FILL;
      k      <= '0;
      base   <= '0;
      count  <= '0;
    end else if (cfg_load) begin
      len    <= len_c;
      hop    <= hop_c;
      win_en <= cfg_win_en;
      state  <= S_FILL;
      k      <= '0;
      base   <= '0;
      count  <= '0;
    end else begin
      count <= cnt_after;
      if (state == S_FILL) begin
        if (count >= len) state <= S_EMIT;
      end else if (issue) begin
        if (issue_last) begin
          // hop==MAX_FRAME truncates to 0, which is the correct modular advance
          base <= base + hop[AW-1:0];
          k    <= '0;
          if (cnt_after < len) state <= S_FILL;
        end else begin
          k <= k + AW'(1);
        end
      end
    end
  end

  // sample buffer write port
  always_ff @(posedge clk) begin
    if (wr) sbuf[wr_addr] <= st.in_data;
  end

  // window RAM write port; registered read below returns old data on a collision
  always_ff @(posedge clk) begin
    if (coef_wr_en) cmem[coef_wr_addr] <= coef_wr_data;
  end

  assign vld_pipe[0] = issue;
  assign fst_pipe[0] = issue & (k == '0);
  assign lst_pipe[0] = issue_last;

  // valid/first/last shift register; cfg_load abandons everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[STAGES:1] <= '0;
      fst_pipe[STAGES:1] <= '0;
      lst_pipe[STAGES:1] <= '0;
    end else if (cfg_load) begin
      vld_pipe[STAGES:1] <= '0;
      fst_pipe[STAGES:1] <= '0;
      lst_pipe[STAGES:1] <= '0;
    end else if (!stall) begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      fst_pipe[STAGES:1] <= fst_pipe[STAGES-1:0];
      lst_pipe[STAGES:1] <= lst_pipe[STAGES-1:0];
    end
  end

  // stage 1 memory reads and stage 2 multiply; data is qualified by vld_pipe
  always_ff @(posedge clk) begin
    if (issue) begin
      s1_smp  <= sbuf[rd_addr];
      s1_coef <= cmem[k];
    end
    if (!stall) begin
      s2_prod <= PW'(s1_smp) * PW'(s1_coef);
      s2_smp  <= s1_smp;
    end
  end

  // round half up, then saturate to the sample range
  always_comb begin
    rnd = s2_prod + RND;
    shf = rnd >>> (COEF_W - 1);
    if (shf > SAT_HI)      win_res = SAT_HI[DATA_W-1:0];
    else if (shf < SAT_LO) win_res = SAT_LO[DATA_W-1:0];
    else                   win_res = shf[DATA_W-1:0];
  end

  // stage 3 output register; bypass keeps the same latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        out_q <= '0;
    else if (!cfg_load && !stall && vld_pipe[2])    out_q <= win_en ? win_res : s2_smp;
  end

  assign st.in_ready  = in_rdy;
  assign st.out_data  = out_q;
  assign st.out_valid = vld_pipe[STAGES];
  assign st.out_first = fst_pipe[STAGES];
  assign st.out_last  = lst_pipe[STAGES];
  assign busy         = (state == S_EMIT) | (|vld_pipe[STAGES:1]);
endmodule

// File: tb/tb_frame_window_stream.sv
// Directed + randomized bench for frame_window_stream against a frame-level reference model.
module tb_frame_window_stream;
  localparam int MAXF = 16;

  logic clk = 1'b0;
  logic rst;
  logic cfg_load, cfg_win_en, coef_wr_en, busy;
  logic [4:0] cfg_frame_len, cfg_hop;
  logic [3:0] coef_wr_addr;
  logic signed [15:0] coef_wr_data;

  frame_window_stream_if #(.DATA_W(16)) ifc();

  frame_window_stream #(.DATA_W(16), .COEF_W(16), .MAX_FRAME(MAXF)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_frame_len(cfg_frame_len),
    .cfg_hop(cfg_hop), .cfg_win_en(cfg_win_en), .coef_wr_en(coef_wr_en),
    .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data), .st(ifc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int d; bit f; bit l; } ob_t;

  int  n_chk = 0, n_pass = 0, n_fail = 0;
  int  stim[$], acc[$], acc_t[$];
  ob_t outq[$];
  int  m_coef[MAXF];
  int  m_len, m_hop;
  bit  m_win;
  int  cyc = 0, n_last, first_ov, ov_run, ov_max, viol, low_seen;
  bit  s_acc, s_in_ready, s_ov;

  task automatic chk(string tag, logic signed [31:0] got, logic signed [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // spec arithmetic on plain integers
  function automatic int win(int s, int c, bit en);
    longint p;
    if (!en) return s;
    p = (longint'(s) * longint'(c) + 64'sd16384) >>> 15;
    if (p > 32767) p = 32767;
    else if (p < -32768) p = -32768;
    return int'(p);
  endfunction

  task automatic model_reset(int l, int h, bit w);
    m_len = l; m_hop = h; m_win = w;
    acc.delete(); acc_t.delete(); outq.delete();
    n_last = 0; first_ov = -1; ov_run = 0; ov_max = 0; viol = 0; low_seen = 0;
  endtask

  // entered at a negedge with inputs set; samples the cycle, returns at next negedge
  task automatic tick();
    #1;
    cyc++;
    s_acc = ifc.in_valid && ifc.in_ready;
    s_in_ready = ifc.in_ready;
    s_ov = ifc.out_valid;
    if (s_acc) begin acc.push_back(int'(ifc.in_data)); acc_t.push_back(cyc); end
    if (ifc.out_valid && ifc.out_ready) begin
      outq.push_back('{d: int'(ifc.out_data), f: ifc.out_first, l: ifc.out_last});
      if (ifc.out_last) n_last++;
    end
    if (ifc.out_valid) begin
      if (first_ov < 0) first_ov = cyc;
      ov_run++;
      if (ov_run > ov_max) ov_max = ov_run;
    end else ov_run = 0;
    if (!ifc.in_ready && !cfg_load) begin
      low_seen++;
      if (acc.size() - m_hop * n_last < MAXF) viol++;
    end
    @(negedge clk);
  endtask

  task automatic coef(int i, int v);
    logic [15:0] t;
    t = 16'(v);
    coef_wr_en = 1'b1; coef_wr_addr = 4'(i); coef_wr_data = t;
    m_coef[i] = int'($signed(t));
    tick();
    coef_wr_en = 1'b0;
  endtask

  task automatic cfg(int l, int h, bit w, int ml, int mh);
    cfg_frame_len = 5'(l); cfg_hop = 5'(h); cfg_win_en = w; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    model_reset(ml, mh, w);
  endtask

  // feed stim continuously, random out_ready at pct %, until drained
  task automatic run(int pct, int cap);
    int idle = 0, n = 0;
    while (idle < 6 && n < cap) begin
      ifc.in_valid  = stim.size() > 0;
      ifc.in_data   = (stim.size() > 0) ? 16'(stim[0]) : 16'd0;
      ifc.out_ready = $urandom_range(99) < pct;
      tick();
      if (s_acc) void'(stim.pop_front());
      if (stim.size() == 0 && !busy && !s_ov) idle++; else idle = 0;
      n++;
    end
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    chk("run_drained", idle >= 6, 1);
  endtask

  // expected frames: frame f is accepted samples [f*hop, f*hop+len)
  task automatic compare(string tag);
    int nf, j;
    nf = (acc.size() >= m_len) ? (acc.size() - m_len) / m_hop + 1 : 0;
    chk({tag, "_count"}, outq.size(), nf * m_len);
    for (int f = 0; f < nf; f++)
      for (int i = 0; i < m_len; i++) begin
        j = f * m_len + i;
        if (j < outq.size()) begin
          chk({tag, "_data"},  outq[j].d, win(acc[f * m_hop + i], m_coef[i], m_win));
          chk({tag, "_first"}, outq[j].f, i == 0);
          chk({tag, "_last"},  outq[j].l, i == m_len - 1);
        end
      end
  endtask

  initial begin
    int n;
    rst = 1'b1; cfg_load = 1'b0; cfg_frame_len = '0; cfg_hop = '0; cfg_win_en = 1'b0;
    coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0;
    ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.out_ready = 1'b1;
    model_reset(16, 8, 1'b1);
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_out_data",  ifc.out_data, 0);
    chk("rst_first",     ifc.out_first, 0);
    chk("rst_last",      ifc.out_last, 0);
    chk("rst_in_ready",  ifc.in_ready, 1);
    rst = 1'b0;

    // basic windowing with half-scale window
    for (int i = 0; i < 8; i++) coef(i, 16'h4000);
    cfg(8, 8, 1'b1, 8, 8);
    for (int i = 0; i < 8; i++) stim.push_back(1001 + i);
    run(100, 200);
    compare("basic");
    chk("basic_o0", outq[0].d, 501);
    chk("basic_o1", outq[1].d, 501);
    chk("basic_o2", outq[2].d, 502);
    chk("basic_o7", outq[7].d, 504);
    chk("basic_latency", first_ov - acc_t[7], 5);

    // overlap, bypass, back-to-back frames
    for (int i = 0; i < 8; i++) coef(i, 16'h7FFF);
    cfg(8, 4, 1'b0, 8, 4);
    for (int i = 0; i < 20; i++) stim.push_back(i);
    run(100, 300);
    compare("overlap");
    chk("overlap_nobubble", ov_max, 32);

    // rounding and saturation corners
    coef(0, 16'h8000); coef(1, 16'h7FFF); coef(2, 16'h4000); coef(3, 16'h4000);
    cfg(4, 4, 1'b1, 4, 4);
    stim.push_back(-32768); stim.push_back(1000); stim.push_back(-3); stim.push_back(3);
    run(100, 200);
    compare("sat");
    chk("sat_max",  outq[0].d, 32767);
    chk("sat_unity", outq[1].d, 1000);
    chk("sat_neg",  outq[2].d, -1);

    // config clamping: len<2 -> 2 with hop>len -> len; len>MAX -> MAX with hop 0 -> len
    cfg(1, 7, 1'b0, 2, 2);
    for (int i = 0; i < 6; i++) stim.push_back(50 + i);
    run(100, 200);
    compare("clamp_lo");
    cfg(20, 0, 1'b0, 16, 16);
    for (int i = 0; i < 16; i++) stim.push_back(-100 - i);
    run(100, 200);
    compare("clamp_hi");

    // backpressure and wrap at len=MAX, hop=5
    for (int i = 0; i < MAXF; i++) coef(i, int'($urandom));
    cfg(16, 5, 1'b1, 16, 5);
    for (int i = 0; i < 200; i++) stim.push_back(int'($signed(16'($urandom))));
    run(30, 20000);
    chk("bp_accepted", acc.size(), 200);
    compare("bp");
    chk("bp_inready_early_low", viol, 0);
    chk("bp_inready_low_seen", low_seen > 0, 1);

    // cfg_load during the 3rd output of a frame
    cfg(8, 8, 1'b0, 8, 8);
    for (int i = 0; i < 8; i++) stim.push_back(100 + i);
    n = 0;
    while (outq.size() < 2 && n < 100) begin
      ifc.in_valid = stim.size() > 0;
      ifc.in_data  = (stim.size() > 0) ? 16'(stim[0]) : 16'd0;
      ifc.out_ready = 1'b1;
      tick();
      if (s_acc) void'(stim.pop_front());
      n++;
    end
    chk("mid_two_out", outq.size(), 2);
    stim.delete();
    cfg_frame_len = 5'd4; cfg_hop = 5'd4; cfg_win_en = 1'b0; cfg_load = 1'b1;
    ifc.in_valid = 1'b1; ifc.in_data = 16'd7777;
    tick();
    cfg_load = 1'b0; ifc.in_valid = 1'b0;
    chk("mid_cfg_inready", s_in_ready, 0);
    chk("mid_cfg_active_out", s_ov, 1);
    chk("mid_no_last", n_last, 0);
    chk("mid_out_valid_next", ifc.out_valid, 0);
    model_reset(4, 4, 1'b0);
    for (int i = 0; i < 8; i++) stim.push_back(200 + i);
    run(100, 200);
    compare("mid");

    // async reset between edges during EMIT
    cfg(8, 8, 1'b1, 8, 8);
    for (int i = 0; i < 16; i++) stim.push_back(300 + 7 * i);
    n = 0;
    s_ov = 1'b0;
    while (!s_ov && n < 50) begin
      ifc.in_valid = stim.size() > 0;
      ifc.in_data  = (stim.size() > 0) ? 16'(stim[0]) : 16'd0;
      ifc.out_ready = 1'b1;
      tick();
      if (s_acc) void'(stim.pop_front());
      n++;
    end
    chk("arst_emitting", s_ov, 1);
    ifc.in_valid = 1'b0;
    stim.delete();
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", ifc.out_valid, 0);
    chk("arst_busy",      busy, 0);
    chk("arst_first",     ifc.out_first, 0);
    chk("arst_last",      ifc.out_last, 0);
    chk("arst_data",      ifc.out_data, 0);
    chk("arst_in_ready",  ifc.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset(16, 8, 1'b1);
    for (int i = 0; i < 24; i++) stim.push_back(int'($signed(16'($urandom))));
    run(100, 400);
    compare("por");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
